// File: rtl/jk_seq_driver.sv
// Serializes a target y pattern into JK excitations for a two-state Moore FSM,
// mirrors the FSM state internally and flags any divergence of the fed-back y.
module jk_seq_driver #(
    parameter int WIDTH  = 8,
    parameter bit DC_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             j,
    output logic             k,
    output logic             drv_valid,
    input  logic             y_fb,
    output logic             mismatch,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             q_q, q_d;
    logic             chk_en_q, chk_en_d;
    logic             mismatch_q, mismatch_d;
    logic             t;

    assign t        = shift_q[WIDTH-1];
    assign mismatch = mismatch_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            q_q        <= 1'b0;
            chk_en_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            q_q        <= q_d;
            chk_en_q   <= chk_en_d;
            mismatch_q <= mismatch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        q_d        = q_q;
        chk_en_d   = chk_en_q;
        mismatch_d = mismatch_q;
        in_ready   = 1'b0;
        j          = 1'b0;
        k          = 1'b0;
        drv_valid  = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d    = in_data;
                    count_d    = CW'(WIDTH);
                    mismatch_d = 1'b0;
                    chk_en_d   = 1'b0;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                drv_valid = 1'b1;
                // Only the input that can change the state is forced; the other is don't-care.
                if (!q_q) begin
                    j = t;
                    k = DC_VAL;
                end else begin
                    j = DC_VAL;
                    k = ~t;
                end
                if (chk_en_q && (y_fb != q_q)) begin
                    mismatch_d = 1'b1;
                end
                q_d      = t;
                shift_d  = {shift_q[WIDTH-2:0], 1'b0};
                count_d  = count_q - CW'(1);
                chk_en_d = 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                done = 1'b1;
                if (y_fb != q_q) begin
                    mismatch_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_jk_seq_driver.sv
// Directed bench for jk_seq_driver: table of words looped back through a JK FSM
// model, plus hand-written reset, busy and DC_VAL=1 sequences.
module tb_jk_seq_driver;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready, j, k, drv_valid, mismatch, done;
    logic             y_fb, y_model, force_zero = 1'b0;

    logic             in_valid2 = 1'b0;
    logic [WIDTH-1:0] in_data2 = '0;
    logic             in_ready2, j2, k2, drv_valid2, mismatch2, done2;
    logic             y_model2;

    int vec_count  = 0;
    int fail_count = 0;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] jk_exp;
        bit          fault;
        bit          hold;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    jk_seq_driver #(.WIDTH(WIDTH), .DC_VAL(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .j(j), .k(k), .drv_valid(drv_valid), .y_fb(y_fb), .mismatch(mismatch), .done(done)
    );

    jk_seq_driver #(.WIDTH(WIDTH), .DC_VAL(1'b1)) dut_dc1 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .j(j2), .k(k2), .drv_valid(drv_valid2), .y_fb(y_model2), .mismatch(mismatch2), .done(done2)
    );

    // Reference JK flip-flop standing in for the downstream FSM.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_model  <= 1'b0;
            y_model2 <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   y_model <= 1'b1;
                2'b01:   y_model <= 1'b0;
                2'b11:   y_model <= ~y_model;
                default: y_model <= y_model;
            endcase
            case ({j2, k2})
                2'b10:   y_model2 <= 1'b1;
                2'b01:   y_model2 <= 1'b0;
                2'b11:   y_model2 <= ~y_model2;
                default: y_model2 <= y_model2;
            endcase
        end
    end

    assign y_fb = force_zero ? 1'b0 : y_model;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkIdle(input string tag, input logic mm_exp);
        checkOutput({tag, " in_ready"}, 16'(in_ready), 16'd1);
        checkOutput({tag, " jk"}, 16'({j, k}), 16'd0);
        checkOutput({tag, " drv_valid"}, 16'(drv_valid), 16'd0);
        checkOutput({tag, " done"}, 16'(done), 16'd0);
        checkOutput({tag, " mismatch"}, 16'(mismatch), 16'(mm_exp));
    endtask

    // Offers one word, then checks every cycle up to and including the return to IDLE.
    // Returns #1 after the edge that re-enters IDLE, so a following call is back-to-back.
    task automatic applyStimulus(input vec_t v);
        logic mm_exp, mm_next;
        int   budget;
        budget = 0;
        while (!in_ready && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready) checkOutput("in_ready timeout", 16'(in_ready), 16'd1);
        force_zero = v.fault;
        in_valid   = 1'b1;
        in_data    = v.data;
        @(posedge clk); #1;
        mm_exp = 1'b0;
        for (int c = 1; c <= WIDTH + 1; c++) begin
            if (v.hold && c <= WIDTH) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            checkOutput($sformatf("w%0h c%0d in_ready", v.data, c), 16'(in_ready), 16'd0);
            checkOutput($sformatf("w%0h c%0d mismatch", v.data, c), 16'(mismatch), 16'(mm_exp));
            mm_next = mm_exp;
            if (c <= WIDTH) begin
                checkOutput($sformatf("w%0h c%0d jk", v.data, c), 16'({j, k}),
                            16'(v.jk_exp[15-2*(c-1) -: 2]));
                checkOutput($sformatf("w%0h c%0d drv_valid", v.data, c), 16'(drv_valid), 16'd1);
                checkOutput($sformatf("w%0h c%0d done", v.data, c), 16'(done), 16'd0);
            end else begin
                checkOutput($sformatf("w%0h c%0d jk", v.data, c), 16'({j, k}), 16'd0);
                checkOutput($sformatf("w%0h c%0d drv_valid", v.data, c), 16'(drv_valid), 16'd0);
                checkOutput($sformatf("w%0h c%0d done", v.data, c), 16'(done), 16'd1);
            end
            if (c >= 2) begin
                if (!v.fault)
                    checkOutput($sformatf("w%0h c%0d y_fb", v.data, c), 16'(y_fb), 16'(v.data[9-c]));
                else if (v.data[9-c] != 1'b0)
                    mm_next = 1'b1;
            end
            @(posedge clk); #1;
            mm_exp = mm_next;
        end
        force_zero = 1'b0;
        checkIdle($sformatf("w%0h end", v.data), mm_exp);
    endtask

    initial begin
        vecs[0] = '{8'hFF, 16'h8000, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 16'h4000, 1'b0, 1'b0};
        vecs[2] = '{8'hA5, 16'h9926, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 16'h4804, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 16'h8000, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 16'h4000, 1'b0, 1'b0};
        vecs[6] = '{8'hA5, 16'h9926, 1'b0, 1'b1};

        #2;
        checkIdle("reset held", 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkIdle($sformatf("idle %0d", i), 1'b0);
        end

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Async reset while bit 3 of A5 is on j/k.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("pre-reset drv_valid", 16'(drv_valid), 16'd1);
        rst = 1'b0;
        #1;
        checkIdle("async reset", 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("post-reset done %0d", i), 16'(done), 16'd0);
        end
        applyStimulus('{8'h80, 16'h9000, 1'b0, 1'b0});

        // DC_VAL=1 instance, still at q=0 since reset.
        in_valid2 = 1'b1;
        in_data2  = 8'h00;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        for (int c = 1; c <= WIDTH; c++) begin
            checkOutput($sformatf("dc1 c%0d jk", c), 16'({j2, k2}), 16'b01);
            checkOutput($sformatf("dc1 c%0d y", c), 16'(y_model2), 16'd0);
            checkOutput($sformatf("dc1 c%0d drv_valid", c), 16'(drv_valid2), 16'd1);
            @(posedge clk); #1;
        end
        checkOutput("dc1 done", 16'(done2), 16'd1);
        checkOutput("dc1 mismatch", 16'(mismatch2), 16'd0);
        @(posedge clk); #1;
        checkOutput("dc1 in_ready", 16'(in_ready2), 16'd1);
        checkOutput("dc1 mismatch end", 16'(mismatch2), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
